fifo_pop_stage: RTL
===================

# fifo_pop_stage

Registered drain stage that sits directly downstream of a non-fall-through FIFO. It pops the FIFO head and presents the data on a valid/ready stream through a 2-entry output buffer (main register plus skid register). All outputs are registered, and `fifo_pop_o` has no combinational dependency on `ready_i`. This breaks the timing path between the FIFO read side and the consumer while still sustaining one transfer per cycle.

## Interface
- `DATA_WIDTH`, default 32: width of the FIFO data and the stream data.
- `CNT_WIDTH`, default 16: width of the transfer counter (only used with the statistics feature).
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `flush_i`, input, 1: synchronous clear of the buffered entries.
- `fifo_empty_i`, input, 1: upstream FIFO empty flag.
- `fifo_data_i`, input, DATA_WIDTH: upstream FIFO head data; valid when `fifo_empty_i`=0.
- `fifo_pop_o`, output, 1: pops the upstream FIFO head this cycle.
- `valid_o`, output, 1: `data_o` holds a valid entry.
- `ready_i`, input, 1: consumer accepts `data_o` this cycle.
- `data_o`, output, DATA_WIDTH: oldest buffered entry.
- `count_o`, output, CNT_WIDTH: number of completed transfers (statistics feature only).

## Operation
- State: main register `m_q` with `m_vld_q`, skid register `s_q` with `s_vld_q`. Occupancy `occ` is 0, 1 or 2.
  - Invariant: `s_vld_q` implies `m_vld_q`.
- Outputs:
  - `valid_o` = `m_vld_q`
  - `data_o` = `m_q`
  - `fifo_pop_o` = !`fifo_empty_i` && !`s_vld_q` && !`flush_i`
- Push and pop events:
  - push = `fifo_pop_o`; the data written is `fifo_data_i`.
  - pop = `valid_o` && `ready_i`.
- Next state by occupancy and event:
  - occ 0, push: `m` ← data; occ becomes 1.
  - occ 1, push only: `s` ← data; occ becomes 2.
  - occ 1, pop only: occ becomes 0.
  - occ 1, push and pop: `m` ← data; occ stays 1.
  - occ 2, pop: `m` ← `s`, `s` invalidated; occ becomes 1. Push cannot occur at occ 2.
- Ordering: strict FIFO order is preserved; no entry is dropped or duplicated.
- `valid_o` handshake rule: once asserted, `valid_o` stays high and `data_o` stays stable until pop or flush.
- `flush_i`: at the next edge both valid bits clear. The same cycle forces `fifo_pop_o`=0 and no pop is counted.
  - The upstream FIFO is flushed by its own `flush_i`, driven in parallel.
- `rst_i`: same effect as `flush_i`, and additionally clears `count_o`. A reset mid-transfer discards buffered data with no pop completed.
- `rst_i` and `flush_i` both high: behaves as reset.
- Data registers are not reset; only the valid bits and the counter are.

## Timing
- Reset values:
  - `valid_o`=0
  - `data_o`=don't-care (must not be X-checked while `valid_o`=0)
  - `fifo_pop_o`=!`fifo_empty_i` (combinational on the input, 0 while `rst_i`=1)
  - `count_o`=0
- Latency: FIFO head popped in cycle N appears on `data_o` with `valid_o`=1 in cycle N+1.
- Throughput: 1 transfer/cycle sustained when `ready_i`=1 continuously and the FIFO is non-empty.
- Backpressure: with `ready_i`=0, at most 2 pops occur before `fifo_pop_o` drops. `fifo_pop_o` reasserts in the cycle after the first pop that frees the skid register.
- Combinational paths:
  - `fifo_empty_i` → `fifo_pop_o`
  - `s_vld_q` → `fifo_pop_o`
  - `flush_i` → `fifo_pop_o`
  - No path from `ready_i` to any output.

## Configuration
- Macro: `FIFO_POP_STAGE_STATS_EN`.
- Defined:
  - `count_o` increments by 1 on every pop, wrapping modulo 2^CNT_WIDTH.
  - Cleared only by `rst_i`; `flush_i` does not clear it.
- Undefined:
  - The counter is not instantiated and `count_o` is tied to 0.
  - The port list is unchanged.

## Test plan
- Reset then FIFO holding 0xA1, 0xA2, 0xA3 with `ready_i`=1 → `data_o` shows 0xA1, 0xA2, 0xA3 on consecutive cycles starting 1 cycle after the first pop; `fifo_pop_o` high 3 cycles.
- FIFO non-empty, `ready_i`=0 for 5 cycles → exactly 2 pops; `valid_o`=1 with `data_o` frozen at the first value; release `ready_i` → data arrives in order with no gap or loss.
- Alternating `ready_i` (1,0,1,0…) over 8 entries 0x10..0x17 → all 8 received in order; occupancy never exceeds 2.
- Occupancy 2, then `flush_i` for 1 cycle → `valid_o`=0 the next cycle; `fifo_pop_o`=0 during the flush cycle; no stale data emitted later.
- `rst_i` asserted mid-stream while occupancy is 1 → `valid_o`=0 next cycle and `count_o`=0; traffic restarts cleanly after release.
- With `FIFO_POP_STAGE_STATS_EN`, CNT_WIDTH=4, 18 transfers → `count_o`=2 (wrapped). Without the macro → `count_o`=0 throughout.

Source files
------------

// File: rtl/fifo_pop_stage.sv
// fifo_pop_stage: registered drain stage for a non-fall-through FIFO.
// Pops the FIFO head into a main/skid register pair and presents it on a
// valid/ready stream. The FIFO pop does not depend on the consumer's ready.
// Optional transfer counter enabled by defining FIFO_POP_STAGE_STATS_EN;
// without it count_o is tied to zero.
module fifo_pop_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]  count_o
);

  logic [DATA_WIDTH-1:0] m_q;
  logic [DATA_WIDTH-1:0] s_q;
  logic                  m_vld_q;
  logic                  s_vld_q;
  logic                  m_vld_d;
  logic                  s_vld_d;
  logic                  push;
  logic                  pop;
  logic                  ld_m_in;
  logic                  ld_m_skid;
  logic                  ld_s_in;

  // Pop only when the skid slot is free, so the decision never sees ready_i.
  assign fifo_pop_o = !fifo_empty_i && !s_vld_q && !flush_i && !rst_i;
  assign push       = fifo_pop_o;
  assign pop        = m_vld_q && ready_i;
  assign valid_o    = m_vld_q;
  assign data_o     = m_q;

  // Next occupancy and data-load selects from current occupancy and events.
  always_comb begin
    m_vld_d   = m_vld_q;
    s_vld_d   = s_vld_q;
    ld_m_in   = 1'b0;
    ld_m_skid = 1'b0;
    ld_s_in   = 1'b0;
    if (rst_i || flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else begin
      case ({s_vld_q, m_vld_q})
        2'b00: begin
          if (push) begin
            ld_m_in = 1'b1;
            m_vld_d = 1'b1;
          end
        end
        2'b01: begin
          if (push && pop) begin
            ld_m_in = 1'b1;
          end else if (push) begin
            ld_s_in = 1'b1;
            s_vld_d = 1'b1;
          end else if (pop) begin
            m_vld_d = 1'b0;
          end
        end
        2'b11: begin
          if (pop) begin
            ld_m_skid = 1'b1;
            s_vld_d   = 1'b0;
          end
        end
        default: begin
          // Skid valid without main valid is unreachable; recover to empty.
          m_vld_d = 1'b0;
          s_vld_d = 1'b0;
        end
      endcase
    end
  end

  // Valid bits: the only reset state of the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  // Data registers: load-enabled only, never reset.
  always_ff @(posedge clk_i) begin
    if (ld_m_in) begin
      m_q <= fifo_data_i;
    end else if (ld_m_skid) begin
      m_q <= s_q;
    end
    if (ld_s_in) begin
      s_q <= fifo_data_i;
    end
  end

`ifdef FIFO_POP_STAGE_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Completed-transfer counter; survives flush, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (pop && !flush_i) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign count_o = cnt_q;
`else
  assign count_o = '0;
`endif

endmodule
